// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcode
// encodings driven by the control unit and a conditional-negate helper.
package mul_div_unit_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   localparam int unsigned MD_ITERS = 32;

   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
      return n ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mul_div_unit_iter_step.sv
// One iteration of the MSB-first datapath: shift-add for multiply,
// restoring subtract for divide. Purely combinational.
module md_iter_step (
   input  logic [63:0] acc_i,
   input  logic [31:0] opnd_i,
   input  logic        bit_i,
   input  logic        div_i,
   output logic [63:0] acc_o
);

   logic [32:0] trial;
   logic [32:0] diff;

   always_comb begin
      acc_o = '0;
      // Divide: acc holds {remainder, quotient}; the next dividend bit shifts into the remainder.
      trial = {acc_i[63:32], bit_i};
      diff  = trial - {1'b0, opnd_i};
      if (div_i) begin
         if (!diff[32]) begin
            acc_o = {diff[31:0], acc_i[30:0], 1'b1};
         end else begin
            acc_o = {trial[31:0], acc_i[30:0], 1'b0};
         end
      end else begin
         acc_o = {acc_i[62:0], 1'b0} + (bit_i ? {32'd0, opnd_i} : 64'd0);
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// 33-cycle busy window per mult/div; mthi/mtlo write in a single edge.
module mul_div_unit
   import mul_div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [63:0] acc_q, acc_d, acc_step, prod;
   logic [31:0] opa_q, opa_d, opb_q, opb_d;
   logic        is_div_q, is_div_d, neg_q, neg_d, sa_q, sa_d, bz_q, bz_d;
   logic        md_op, signed_op;

   assign md_op     = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   assign signed_op = (op == MD_MULT) || (op == MD_DIV);
   assign prod      = neg_q ? (~acc_q + 64'd1) : acc_q;

   md_iter_step u_step (
      .acc_i  (acc_q),
      .opnd_i (is_div_q ? opb_q : opa_q),
      .bit_i  (is_div_q ? opa_q[5'd31 - cnt_q] : opb_q[5'd31 - cnt_q]),
      .div_i  (is_div_q),
      .acc_o  (acc_step)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_d    = acc_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      sa_d     = sa_q;
      bz_d     = bz_q;
      case (state_q)
         IDLE: begin
            if (start && md_op) begin
               opa_d    = neg_if(A, signed_op && A[31]);
               opb_d    = neg_if(B, signed_op && B[31]);
               sa_d     = signed_op && A[31];
               neg_d    = signed_op && (A[31] ^ B[31]);
               is_div_d = (op == MD_DIV) || (op == MD_DIVU);
               bz_d     = (B == 32'd0);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = CALC;
            end else if (start && (op == MD_MTHI)) begin
               hi_d = A;
            end else if (start && (op == MD_MTLO)) begin
               lo_d = A;
            end
         end
         CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(MD_ITERS - 1)) state_d = FIX;
         end
         FIX: begin
            // Divide by zero yields an all-ones quotient; the remainder already equals A.
            if (is_div_q) begin
               lo_d = bz_q ? 32'hFFFF_FFFF : neg_if(acc_q[31:0], neg_q);
               hi_d = neg_if(acc_q[63:32], sa_q);
            end else begin
               lo_d = prod[31:0];
               hi_d = prod[63:32];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      bz_q     <= bz_d;
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
